// File: rtl/eespfal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eespfal_pkg                                                     |
// | Purpose  : Shared types and constants for the EESPFAL phase sequencer.     |
// |            Sequencer state encoding and operation-counter limits.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package eespfal_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    EVAL   = 3'd2,
    SAMPLE = 3'd3,
    DISCH  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int                 OPCNT_W   = 16;
  localparam logic [OPCNT_W-1:0] OPCNT_MAX = 16'hFFFF;

endpackage : eespfal_pkg
`default_nettype wire

// File: rtl/eespfal_interval_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eespfal_interval_cnt                                            |
// | Purpose  : Loadable down-counter timing the sequencer phase intervals.     |
// |            Stops at zero; zero flag is combinational from the count.       |
// | Ports    : clk, rst (async, active-high)                                   |
// |            load      - load load_val this cycle (overrides decrement)      |
// |            load_val  - value loaded, i.e. interval length minus one        |
// |            zero      - current count is zero                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module eespfal_interval_cnt
  import eespfal_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule : eespfal_interval_cnt
`default_nettype wire

// File: rtl/eespfal_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eespfal_phase_sequencer                                         |
// | Purpose  : Drives the 4-bit EESPFAL switch macro: dual-rail operands,      |
// |            per-lane power clock, discharge and discharge-phase strobe.     |
// |            Captures the dual-rail result and returns it on a handshake.    |
// | Ports    : wb_clk_i/wb_rst_i         clock, async active-high reset        |
// |            in_valid/in_ready/x_in/k_in   operand handshake                 |
// |            abort                         cancel current op, force discharge|
// |            clk_top/dis_top/Dis_Phase_top macro phase controls              |
// |            x_top/x_bar_top/k_top/k_bar_top dual-rail operands to the macro |
// |            s_top/s_bar_top               dual-rail result from the macro   |
// |            out_valid/out_ready/s_out/rail_err  result handshake            |
// |            op_count                      completed ops, saturating         |
// | Config   : EESPFAL_RAIL_CHECK_EN - enables the rail-integrity check on     |
// |            s_top/s_bar_top; when undefined rail_err is tied low.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module eespfal_phase_sequencer
  import eespfal_pkg::*;
#(
  parameter int BIT_SIZE  = 4,
  parameter int SETUP_CYC = 2,
  parameter int EVAL_CYC  = 4,
  parameter int DIS_CYC   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] x_in,
  input  logic [BIT_SIZE-1:0] k_in,
  input  logic                abort,
  output logic [BIT_SIZE-1:0] clk_top,
  output logic [BIT_SIZE-1:0] dis_top,
  output logic                Dis_Phase_top,
  output logic [BIT_SIZE-1:0] x_top,
  output logic [BIT_SIZE-1:0] x_bar_top,
  output logic [BIT_SIZE-1:0] k_top,
  output logic [BIT_SIZE-1:0] k_bar_top,
  input  logic [BIT_SIZE-1:0] s_top,
  input  logic [BIT_SIZE-1:0] s_bar_top,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] s_out,
  output logic                rail_err,
  output logic [OPCNT_W-1:0]  op_count
);

  state_t               state;
  state_t               next_state;
  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_val;
  logic                 cnt_zero;
  logic                 aborted;
  logic                 active;
  logic [BIT_SIZE-1:0]  s_cap;
  logic                 rail_flag;
  logic [OPCNT_W-1:0]   op_cnt;

  assign active = (state == SETUP) || (state == EVAL) || (state == SAMPLE);

  eespfal_interval_cnt #(
    .CNT_W    (CNT_W)
  ) u_interval_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Next-state logic. abort is tested before the interval expiry so that it
  // wins a same-cycle race with the counter.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = SETUP;
      SETUP:   if (abort) next_state = DISCH;
               else if (cnt_zero) next_state = EVAL;
      EVAL:    if (abort) next_state = DISCH;
               else if (cnt_zero) next_state = SAMPLE;
      SAMPLE:  next_state = DISCH;
      DISCH:   if (cnt_zero) next_state = aborted ? IDLE : DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Interval counter is reloaded on every state change with the length of
  // the state being entered minus one; untimed states load zero.
  always_comb begin
    cnt_load = (next_state != state);
    cnt_val  = '0;
    case (next_state)
      SETUP:   cnt_val = CNT_W'(SETUP_CYC - 1);
      EVAL:    cnt_val = CNT_W'(EVAL_CYC - 1);
      DISCH:   cnt_val = CNT_W'(DIS_CYC - 1);
      default: cnt_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered outputs, decoded from the state being entered so that each
  // output is aligned with the state it belongs to.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      in_ready      <= 1'b0;
      clk_top       <= '0;
      dis_top       <= '0;
      Dis_Phase_top <= 1'b0;
      x_top         <= '0;
      x_bar_top     <= '0;
      k_top         <= '0;
      k_bar_top     <= '0;
      out_valid     <= 1'b0;
      s_out         <= '0;
      rail_err      <= 1'b0;
      aborted       <= 1'b0;
      s_cap         <= '0;
      op_cnt        <= '0;
    end else begin
      in_ready      <= (next_state == IDLE);
      clk_top       <= {BIT_SIZE{(next_state == EVAL) || (next_state == SAMPLE)}};
      dis_top       <= {BIT_SIZE{next_state == DISCH}};
      Dis_Phase_top <= (next_state == DISCH);
      out_valid     <= (next_state == DONE);

      // Rails are loaded on acceptance, held through SAMPLE, and forced to
      // both-low otherwise (including on abort).
      if (state == IDLE && next_state == SETUP) begin
        x_top     <= x_in;
        x_bar_top <= ~x_in;
        k_top     <= k_in;
        k_bar_top <= ~k_in;
        aborted   <= 1'b0;
      end else if (!(active && next_state != DISCH)) begin
        x_top     <= '0;
        x_bar_top <= '0;
        k_top     <= '0;
        k_bar_top <= '0;
      end

      if (active && abort) begin
        aborted <= 1'b1;
      end

      if (state == SAMPLE && !abort) begin
        s_cap <= s_top;
      end

      if (state == DISCH && next_state == DONE) begin
        s_out    <= s_cap;
        rail_err <= rail_flag;
      end

      if (state == DONE && out_ready && op_cnt != OPCNT_MAX) begin
        op_cnt <= op_cnt + OPCNT_W'(1);
      end
    end
  end

`ifdef EESPFAL_RAIL_CHECK_EN
  logic [BIT_SIZE-1:0] sb_cap;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sb_cap <= '0;
    end else if (state == SAMPLE && !abort) begin
      sb_cap <= s_bar_top;
    end
  end

  // A healthy lane has complementary rails; any equal pair is an error.
  assign rail_flag = |(s_cap ~^ sb_cap);
`else
  logic unused_sbar;
  assign unused_sbar = ^s_bar_top;
  assign rail_flag   = 1'b0;
`endif

  assign op_count = op_cnt;

endmodule : eespfal_phase_sequencer
`default_nettype wire

// File: tb/tb_eespfal_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_eespfal_phase_sequencer                                      |
// | Purpose  : Self-checking bench for eespfal_phase_sequencer. A table of     |
// |            operand/result records is run through full operations, then    |
// |            abort, mid-operation reset and counter saturation sequences.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_eespfal_phase_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  x_in;
  logic [3:0]  k_in;
  logic        abort;
  logic [3:0]  clk_top;
  logic [3:0]  dis_top;
  logic        Dis_Phase_top;
  logic [3:0]  x_top;
  logic [3:0]  x_bar_top;
  logic [3:0]  k_top;
  logic [3:0]  k_bar_top;
  logic [3:0]  s_top;
  logic [3:0]  s_bar_top;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  s_out;
  logic        rail_err;
  logic [15:0] op_count;

  int          errors;
  int          checks;
  logic [15:0] exp_cnt;

  eespfal_phase_sequencer dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .x_in          (x_in),
    .k_in          (k_in),
    .abort         (abort),
    .clk_top       (clk_top),
    .dis_top       (dis_top),
    .Dis_Phase_top (Dis_Phase_top),
    .x_top         (x_top),
    .x_bar_top     (x_bar_top),
    .k_top         (k_top),
    .k_bar_top     (k_bar_top),
    .s_top         (s_top),
    .s_bar_top     (s_bar_top),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .s_out         (s_out),
    .rail_err      (rail_err),
    .op_count      (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] k;
    logic [3:0] s;
    logic [3:0] sb;
    logic [3:0] exp_xb;
    logic [3:0] exp_kb;
    logic       exp_err_chk;   // rail_err expected when the check is built in
    int         hold;          // cycles out_ready is held low in DONE
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    logic [15:0] rails;
    logic        exp_err;
`ifdef EESPFAL_RAIL_CHECK_EN
    exp_err = v.exp_err_chk;
`else
    exp_err = 1'b0;
`endif
    rails     = {v.x, v.exp_xb, v.k, v.exp_kb};
    s_top     = v.s;
    s_bar_top = v.sb;
    wait_ready();
    x_in = v.x; k_in = v.k; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; x_in = 4'h0; k_in = 4'h0;
    for (int c = 0; c < 2; c++) begin
      check("setup_rails", {16'd0, x_top, x_bar_top, k_top, k_bar_top}, {16'd0, rails});
      check("setup_clk_low", {28'd0, clk_top}, 32'h0);
      check("setup_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      check("eval_clk_high", {28'd0, clk_top}, 32'hF);
      check("eval_rails_held", {16'd0, x_top, x_bar_top, k_top, k_bar_top}, {16'd0, rails});
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      check("disch_ctrl", {23'd0, clk_top, dis_top, Dis_Phase_top}, {23'd0, 4'h0, 4'hF, 1'b1});
      check("disch_rails_low", {16'd0, x_top, x_bar_top, k_top, k_bar_top}, 32'h0);
      check("disch_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    check("done_result", {25'd0, out_valid, in_ready, s_out, rail_err},
          {25'd0, 1'b1, 1'b0, v.s, exp_err});
    check("done_ctrl_low", {23'd0, clk_top, dis_top, Dis_Phase_top}, 32'h0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("done_hold_stable", {25'd0, out_valid, in_ready, s_out, rail_err},
            {25'd0, 1'b1, 1'b0, v.s, exp_err});
      check("done_hold_count", {16'd0, op_count}, {16'd0, exp_cnt});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    check("after_handshake", {30'd0, out_valid, in_ready}, 32'b01);
    check("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    errors = 0; checks = 0; exp_cnt = 16'd0;
    rst = 1'b1; in_valid = 1'b0; x_in = 4'h0; k_in = 4'h0; abort = 1'b0;
    s_top = 4'h0; s_bar_top = 4'h0; out_ready = 1'b0;

    //            x     k     s     sb    ~x    ~k    err   hold
    vecs[0] = '{4'hA, 4'h3, 4'h9, 4'h6, 4'h5, 4'hC, 1'b0, 0};
    vecs[1] = '{4'h5, 4'hC, 4'h3, 4'hC, 4'hA, 4'h3, 1'b0, 10};
    vecs[2] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b0, 1};
    vecs[3] = '{4'h6, 4'h9, 4'h9, 4'h7, 4'h9, 4'h6, 1'b1, 2};
    vecs[4] = '{4'h1, 4'h8, 4'hE, 4'hE, 4'hE, 4'h7, 1'b1, 0};

    // Reset state
    #12;
    check("reset_outputs", {17'd0, in_ready, out_valid, rail_err, Dis_Phase_top, clk_top, dis_top, x_top},
          32'h0);
    check("reset_count", {16'd0, op_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("ready_low_at_release", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Abort on the 2nd EVAL cycle
    wait_ready();
    s_top = 4'h9; s_bar_top = 4'h6;
    x_in = 4'hC; k_in = 4'h5; in_valid = 1'b1;
    @(negedge clk);              // SETUP 1
    in_valid = 1'b0;
    @(negedge clk);              // SETUP 2
    @(negedge clk);              // EVAL 1
    check("abort_eval1_clk", {28'd0, clk_top}, 32'hF);
    @(negedge clk);              // EVAL 2
    check("abort_eval2_clk", {28'd0, clk_top}, 32'hF);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("abort_disch_ctrl", {23'd0, clk_top, dis_top, Dis_Phase_top}, {23'd0, 4'h0, 4'hF, 1'b1});
      check("abort_disch_rails", {16'd0, x_top, x_bar_top, k_top, k_bar_top}, 32'h0);
      check("abort_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      check("abort_idle", {24'd0, out_valid, in_ready, dis_top, Dis_Phase_top, 1'b0},
            {24'd0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0});
      check("abort_count", {16'd0, op_count}, {16'd0, exp_cnt});
      @(negedge clk);
    end

    // Reset pulsed during EVAL
    x_in = 4'h3; k_in = 4'hA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_eval_clk", {28'd0, clk_top}, 32'hF);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {19'd0, clk_top, dis_top, Dis_Phase_top, x_top}, 32'h0);
    check("rst_async_rails", {20'd0, x_bar_top, k_top, k_bar_top}, 32'h0);
    check("rst_async_count", {15'd0, in_ready, op_count}, 32'h0);
    exp_cnt = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_again", {31'd0, in_ready}, 32'd1);

    // Back-to-back operations after reset
    run_op(vecs[0]);
    run_op(vecs[2]);

    // Saturation from a preset count
    @(negedge clk);
    force dut.op_cnt = 16'hFFFE;
    #1 release dut.op_cnt;
    exp_cnt = 16'hFFFE;
    run_op(vecs[0]);
    run_op(vecs[1]);
    check("saturated", {16'd0, op_count}, 32'h0000FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_eespfal_phase_sequencer
`default_nettype wire
